mem_stream_controller: RTL and testbench
========================================

MEM_STREAM_CONTROLLER -- requirements
Module: mem_stream_controller

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 10, memory word address width.
REQ-002 SHALL have parameter NUM_VECTORS, default 5, vector-length field width.
REQ-003 SHALL have parameter MIN_VEC_LENGTH, default 16, element width.
REQ-004 SHALL have parameter NUM_TILES_PER_SLICE, default 20, maximum elements per vector.
REQ-005 SHALL have parameter NUM_STREAM_ID, default 5, stream-ID width.
REQ-006 SHALL have parameter CMD_DEPTH, default 4, command FIFO entries (power of 2).
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 15, maximum cycles to wait for mem_ready.
REQ-008 SHALL have ports: clk in 1 clock; rst_n in 1 active-low reset, asynchronous assert.
REQ-009 SHALL have ports: cmd_valid in 1; cmd_ready out 1; cmd_is_write in 1; cmd_address in MEM_ADDR_WIDTH; cmd_length in NUM_VECTORS; cmd_stream_id in NUM_STREAM_ID; cmd_write_data in MIN_VEC_LENGTH x NUM_TILES_PER_SLICE.
REQ-010 SHALL have memory-side ports: mem_read_enable out 1; mem_write_enable out 1; mem_address out MEM_ADDR_WIDTH; mem_vector_length out NUM_VECTORS; mem_write_data out element array; mem_read_data in element array; mem_ready in 1.
REQ-011 SHALL have stream ports: strm_valid out 1; strm_ready in 1; strm_data out element array; strm_stream_id out NUM_STREAM_ID; strm_length out NUM_VECTORS.
REQ-012 SHALL have status ports: wr_done out 1, write-complete pulse; cmd_error out 1, rejected-command pulse; mem_timeout out 1, timeout pulse; busy out 1, state not IDLE or FIFO non-empty.

Function
REQ-013 Command handshake SHALL occur on a clk edge with cmd_valid && cmd_ready; cmd_ready = FIFO not full, with no push while full even if a pop occurs that cycle.
REQ-014 Command with cmd_length == 0 or > NUM_TILES_PER_SLICE SHALL be accepted but not queued, and cmd_error SHALL pulse high for one cycle after the handshake.
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, OUTPUT.
REQ-016 IDLE with FIFO non-empty SHALL pop the head into working registers and go to ISSUE at the next edge.
REQ-017 A push is visible to IDLE one cycle after the handshake edge; there is no bypass.
REQ-018 ISSUE SHALL assert exactly one of mem_read_enable or mem_write_enable for exactly one cycle, drive the working registers onto mem_address, mem_vector_length and mem_write_data, and go to WAIT.
REQ-019 mem_address, mem_vector_length and mem_write_data SHALL stay stable from ISSUE until the return to IDLE.
REQ-020 WAIT on a read with mem_ready SHALL capture mem_read_data into strm_data and go to OUTPUT.
REQ-021 On that capture, elements with index >= length SHALL be forced to 0.
REQ-022 WAIT on a write with mem_ready SHALL pulse wr_done for one cycle and return to IDLE.
REQ-023 WAIT SHALL count cycles without mem_ready; when the count reaches TIMEOUT_CYCLES, it SHALL pulse mem_timeout, drop the command and return to IDLE.
REQ-024 OUTPUT SHALL hold strm_valid high, with strm_data, strm_stream_id and strm_length stable, until strm_ready is high on an edge; it SHALL then go to IDLE.
REQ-025 strm_valid SHALL be high only in OUTPUT.
REQ-026 Read latency with an empty FIFO, IDLE state and single-cycle memory SHALL be: handshake edge T, enable during T+2, mem_ready during T+3, strm_valid during T+4.
REQ-027 Commands SHALL complete strictly in acceptance order, with one command in flight.
REQ-028 mem_ready seen outside WAIT SHALL be ignored.
REQ-029 FIFO pointers SHALL wrap modulo CMD_DEPTH, with a separate count register CMD_DEPTH+1 values wide.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE and empty the FIFO.
REQ-031 rst_n low SHALL set cmd_ready=0, and cmd_ready SHALL be 1 from the first edge after rst_n deasserts.
REQ-032 rst_n low SHALL force all enables, strm_valid, wr_done, cmd_error, mem_timeout and busy to 0.
REQ-033 rst_n low SHALL force strm_data, strm_stream_id, strm_length, mem_address, mem_vector_length, mem_write_data and the timeout counter to 0.
REQ-034 Reset mid-operation SHALL discard the in-flight and queued commands, with no wr_done or strm_valid afterward.
REQ-035 rst_n deassertion SHALL take effect synchronously to clk.

Verification
REQ-036 Read addr=0x010, len=3, id=7, memory returning 0x1111/0x2222/0x3333 and nonzero elements 3..19 -> strm_valid at T+4, data[0..2] as returned, data[3..19]=0, strm_stream_id=7, strm_length=3.
REQ-037 Write addr=0x020, len=20, data[i]=i -> one mem_write_enable pulse with address 0x020, then wr_done one cycle after mem_ready, no strm_valid.
REQ-038 Five back-to-back reads with strm_ready=0 -> cmd_ready drops after the FIFO fills (4 queued plus 1 in OUTPUT); releasing strm_ready outputs five streams in order, IDs 1..5.
REQ-039 Commands len=0 and len=21 -> cmd_error pulses twice, no memory enable, FIFO count unchanged.
REQ-040 mem_ready held low after a read issue -> mem_timeout pulses after 15 WAIT cycles, the next queued command issues.
REQ-041 rst_n low during OUTPUT with 2 queued commands -> strm_valid=0 immediately, busy=0, no further enables after release.

Source files
------------

// File: rtl/mem_stream_controller.sv
// mem_stream_controller: accepts vector read/write commands into a small FIFO,
// issues them one at a time to a single-port vector memory, and presents read
// results on a valid/ready stream. One command is in flight at any time.
module mem_stream_controller #(
    parameter int MEM_ADDR_WIDTH      = 10,
    parameter int NUM_VECTORS         = 5,
    parameter int MIN_VEC_LENGTH      = 16,
    parameter int NUM_TILES_PER_SLICE = 20,
    parameter int NUM_STREAM_ID       = 5,
    parameter int CMD_DEPTH           = 4,
    parameter int TIMEOUT_CYCLES      = 15
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    // command side
    input  logic                                                   cmd_valid,
    output logic                                                   cmd_ready,
    input  logic                                                   cmd_is_write,
    input  logic [MEM_ADDR_WIDTH-1:0]                              cmd_address,
    input  logic [NUM_VECTORS-1:0]                                 cmd_length,
    input  logic [NUM_STREAM_ID-1:0]                               cmd_stream_id,
    input  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]     cmd_write_data,
    // memory side
    output logic                                                   mem_read_enable,
    output logic                                                   mem_write_enable,
    output logic [MEM_ADDR_WIDTH-1:0]                              mem_address,
    output logic [NUM_VECTORS-1:0]                                 mem_vector_length,
    output logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]     mem_write_data,
    input  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]     mem_read_data,
    input  logic                                                   mem_ready,
    // stream side
    output logic                                                   strm_valid,
    input  logic                                                   strm_ready,
    output logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]     strm_data,
    output logic [NUM_STREAM_ID-1:0]                               strm_stream_id,
    output logic [NUM_VECTORS-1:0]                                 strm_length,
    // status
    output logic                                                   wr_done,
    output logic                                                   cmd_error,
    output logic                                                   mem_timeout,
    output logic                                                   busy
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = $clog2(CMD_DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [NUM_VECTORS-1:0] MAX_LEN  = NUM_VECTORS'(NUM_TILES_PER_SLICE);
    localparam logic [CNT_W-1:0]       FULL_CNT = CNT_W'(CMD_DEPTH);
    localparam logic [TMO_W-1:0]       TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] vec_t;

    typedef struct packed {
        logic                      is_write;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [NUM_VECTORS-1:0]    len;
        logic [NUM_STREAM_ID-1:0]  id;
        vec_t                      wdata;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_e;

    state_e           state_q;
    cmd_t             fifo_q [CMD_DEPTH];
    cmd_t             cmd_in;
    cmd_t             cur_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rdy_init_q;
    logic             err_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             len_bad, accept, push, pop, full;
    vec_t             rd_masked_d;

    logic                      mem_rd_en_q, mem_wr_en_q;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
    logic [NUM_VECTORS-1:0]    mem_len_q;
    vec_t                      mem_wdata_q;
    logic                      strm_valid_q;
    vec_t                      strm_data_q;
    logic [NUM_STREAM_ID-1:0]  strm_id_q;
    logic [NUM_VECTORS-1:0]    strm_len_q;
    logic                      wr_done_q, tmo_pulse_q;

    assign cmd_in  = {cmd_is_write, cmd_address, cmd_length, cmd_stream_id, cmd_write_data};
    assign len_bad = (cmd_length == '0) || (cmd_length > MAX_LEN);
    assign full    = (count_q == FULL_CNT);
    // rdy_init_q keeps cmd_ready low until the first edge out of reset
    assign cmd_ready = rdy_init_q && !full;
    assign accept  = cmd_valid && cmd_ready;
    assign push    = accept && !len_bad;
    assign pop     = (state_q == S_IDLE) && (count_q != '0);

    // Occupancy next-state; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, occupancy, ready enable and bad-length error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rdy_init_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rdy_init_q <= 1'b1;
            err_q      <= accept && len_bad;
            count_q    <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage; contents are meaningless while count_q says empty
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= cmd_in;
    end

    // Read data beyond the command's length is zeroed on capture
    always_comb begin
        rd_masked_d = '0;
        for (int i = 0; i < NUM_TILES_PER_SLICE; i++) begin
            if (i < int'(cur_q.len)) rd_masked_d[i] = mem_read_data[i];
        end
    end

    // Command sequencer: IDLE -> ISSUE -> WAIT -> (OUTPUT) -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_len_q    <= '0;
            mem_wdata_q  <= '0;
            strm_valid_q <= 1'b0;
            strm_data_q  <= '0;
            strm_id_q    <= '0;
            strm_len_q   <= '0;
            wr_done_q    <= 1'b0;
            tmo_pulse_q  <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            wr_done_q   <= 1'b0;
            tmo_pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cur_q   <= fifo_q[rd_ptr_q];
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // enable and memory operands launch together; operands then
                    // hold until the next command is issued
                    mem_rd_en_q <= !cur_q.is_write;
                    mem_wr_en_q <= cur_q.is_write;
                    mem_addr_q  <= cur_q.addr;
                    mem_len_q   <= cur_q.len;
                    mem_wdata_q <= cur_q.wdata;
                    tmo_cnt_q   <= '0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        tmo_cnt_q <= '0;
                        if (cur_q.is_write) begin
                            wr_done_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            strm_data_q  <= rd_masked_d;
                            strm_id_q    <= cur_q.id;
                            strm_len_q   <= cur_q.len;
                            strm_valid_q <= 1'b1;
                            state_q      <= S_OUTPUT;
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        // this edge completes TIMEOUT_CYCLES idle waits: drop it
                        tmo_cnt_q   <= '0;
                        tmo_pulse_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (strm_ready) begin
                        strm_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_read_enable   = mem_rd_en_q;
    assign mem_write_enable  = mem_wr_en_q;
    assign mem_address       = mem_addr_q;
    assign mem_vector_length = mem_len_q;
    assign mem_write_data    = mem_wdata_q;
    assign strm_valid        = strm_valid_q;
    assign strm_data         = strm_data_q;
    assign strm_stream_id    = strm_id_q;
    assign strm_length       = strm_len_q;
    assign wr_done           = wr_done_q;
    assign cmd_error         = err_q;
    assign mem_timeout       = tmo_pulse_q;
    assign busy              = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_mem_stream_controller.sv
// Directed bench for mem_stream_controller with a one-cycle-latency memory model.
module tb_mem_stream_controller;
    localparam int AW = 10, LW = 5, EW = 16, NE = 20, IW = 5;
    typedef logic [NE-1:0][EW-1:0] vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, cmd_is_write = 1'b0;
    logic [AW-1:0] cmd_address = '0;
    logic [LW-1:0] cmd_length = '0;
    logic [IW-1:0] cmd_stream_id = '0;
    vec_t cmd_write_data = '0;
    logic mem_read_enable, mem_write_enable;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_vector_length;
    vec_t mem_write_data, mem_read_data = '0;
    logic mem_ready = 1'b0;
    logic strm_valid, strm_ready = 1'b1;
    vec_t strm_data;
    logic [IW-1:0] strm_stream_id;
    logic [LW-1:0] strm_length;
    logic wr_done, cmd_error, mem_timeout, busy;

    int vectors = 0, miscompares = 0;
    int mem_mode = 0;   // 0: ready one cycle after enable, 1: never ready, 2: always ready
    logic en_prev = 1'b0;
    int n_err = 0, n_tmo = 0, n_done = 0, n_en = 0, n_sv = 0;

    always #5 clk = ~clk;

    mem_stream_controller dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_write(cmd_is_write),
        .cmd_address(cmd_address), .cmd_length(cmd_length), .cmd_stream_id(cmd_stream_id),
        .cmd_write_data(cmd_write_data),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_address(mem_address), .mem_vector_length(mem_vector_length),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_ready(mem_ready),
        .strm_valid(strm_valid), .strm_ready(strm_ready), .strm_data(strm_data),
        .strm_stream_id(strm_stream_id), .strm_length(strm_length),
        .wr_done(wr_done), .cmd_error(cmd_error), .mem_timeout(mem_timeout), .busy(busy)
    );

    // memory content: element i at address a
    function automatic vec_t mem_pattern(input logic [AW-1:0] a);
        vec_t v;
        for (int i = 0; i < NE; i++) v[i] = EW'((i + 1) * 'h1111) ^ EW'(a - 10'h010);
        return v;
    endfunction

    // memory model: mem_ready the cycle after an enable cycle
    always @(posedge clk) begin
        #1;
        case (mem_mode)
            0:       mem_ready = en_prev;
            1:       mem_ready = 1'b0;
            default: mem_ready = 1'b1;
        endcase
        mem_read_data = mem_pattern(mem_address);
        en_prev = mem_read_enable || mem_write_enable;
    end

    // pulse/event counters
    always @(negedge clk) begin
        if (cmd_error) n_err++;
        if (mem_timeout) n_tmo++;
        if (wr_done) n_done++;
        if (mem_read_enable || mem_write_enable) n_en++;
        if (strm_valid) n_sv++;
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic clr_counts;
        n_err = 0; n_tmo = 0; n_done = 0; n_en = 0; n_sv = 0;
    endtask

    // call at posedge+1; returns at handshake edge+1
    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l,
                            input logic [IW-1:0] id, input vec_t wd);
        int n;
        cmd_valid = 1'b1; cmd_is_write = wr; cmd_address = a;
        cmd_length = l; cmd_stream_id = id; cmd_write_data = wd;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            vectors++; miscompares++;
            $display("FAIL send_cmd id=%0d: cmd_ready=%b never became 1", id, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
        vectors++; if (strm_valid !== 1'b0) begin miscompares++; $display("FAIL rst_strm_valid: got %b want 0", strm_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if ({mem_read_enable, mem_write_enable, wr_done, cmd_error, mem_timeout} !== 5'b0) begin
            miscompares++; $display("FAIL rst_pulses: got %b want 00000", {mem_read_enable, mem_write_enable, wr_done, cmd_error, mem_timeout}); end
        vectors++; if ({mem_address, mem_vector_length, strm_stream_id, strm_length} !== '0) begin
            miscompares++; $display("FAIL rst_regs: addr %h len %h id %h slen %h want all 0", mem_address, mem_vector_length, strm_stream_id, strm_length); end
        vectors++; if ((strm_data | mem_write_data) !== '0) begin miscompares++; $display("FAIL rst_data: strm %h wdata %h want 0", strm_data, mem_write_data); end
        #2 rst_n = 1'b1;
        #1;
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rel_cmd_ready_pre_edge: got %b want 0", cmd_ready); end
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rel_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_read;
        vec_t exp;
        int en_k, en_n, wr_n, rdy_k, sv_k;
        logic [AW-1:0] en_addr;
        logic [LW-1:0] en_len;
        exp = '0; exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333;
        en_k = -1; en_n = 0; wr_n = 0; rdy_k = -1; sv_k = -1; en_addr = '0; en_len = '0;
        step();
        strm_ready = 1'b0;
        send_cmd(1'b0, 10'h010, 5'd3, 5'd7, '0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_read_enable) begin
                en_n++;
                if (en_k < 0) begin en_k = k; en_addr = mem_address; en_len = mem_vector_length; end
            end
            if (mem_write_enable) wr_n++;
            if (mem_ready && rdy_k < 0) rdy_k = k;
            if (strm_valid && sv_k < 0) sv_k = k;
        end
        vectors++; if (en_k != 2 || en_n != 1) begin miscompares++; $display("FAIL rd_enable: at T+%0d x%0d want T+2 x1", en_k, en_n); end
        vectors++; if (wr_n != 0) begin miscompares++; $display("FAIL rd_no_wr_enable: got %0d want 0", wr_n); end
        vectors++; if (rdy_k != 3) begin miscompares++; $display("FAIL rd_mem_ready: at T+%0d want T+3", rdy_k); end
        vectors++; if (sv_k != 4) begin miscompares++; $display("FAIL rd_strm_valid: at T+%0d want T+4", sv_k); end
        vectors++; if (en_addr !== 10'h010 || en_len !== 5'd3) begin miscompares++; $display("FAIL rd_mem_operands: addr %h len %0d want 010 3", en_addr, en_len); end
        vectors++; if (strm_valid !== 1'b1) begin miscompares++; $display("FAIL rd_hold_valid: got %b want 1", strm_valid); end
        vectors++; if (strm_stream_id !== 5'd7 || strm_length !== 5'd3) begin miscompares++; $display("FAIL rd_id_len: id %0d len %0d want 7 3", strm_stream_id, strm_length); end
        vectors++; if (strm_data !== exp) begin miscompares++; $display("FAIL rd_data: got %h want %h", strm_data, exp); end
        vectors++; if (mem_address !== 10'h010) begin miscompares++; $display("FAIL rd_addr_stable: got %h want 010", mem_address); end
        step();
        strm_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (strm_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rd_release: valid %b busy %b want 0 0", strm_valid, busy); end
    endtask

    task automatic test_write;
        vec_t wd, wd_at_en, wd_at_rdy;
        int wr_k, wr_n, rdy_k, done_k;
        logic [AW-1:0] en_addr;
        for (int i = 0; i < NE; i++) wd[i] = EW'(i);
        wr_k = -1; wr_n = 0; rdy_k = -1; done_k = -1; en_addr = '0; wd_at_en = '0; wd_at_rdy = '0;
        step();
        strm_ready = 1'b1;
        clr_counts();
        send_cmd(1'b1, 10'h020, 5'd20, 5'd3, wd);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_write_enable) begin
                wr_n++;
                if (wr_k < 0) begin wr_k = k; en_addr = mem_address; wd_at_en = mem_write_data; end
            end
            if (mem_ready && rdy_k < 0) begin rdy_k = k; wd_at_rdy = mem_write_data; end
            if (wr_done && done_k < 0) done_k = k;
        end
        vectors++; if (wr_k != 2 || wr_n != 1) begin miscompares++; $display("FAIL wr_enable: at T+%0d x%0d want T+2 x1", wr_k, wr_n); end
        vectors++; if (en_addr !== 10'h020) begin miscompares++; $display("FAIL wr_addr: got %h want 020", en_addr); end
        vectors++; if (wd_at_en !== wd || wd_at_rdy !== wd) begin miscompares++; $display("FAIL wr_data: got %h want %h", wd_at_en, wd); end
        vectors++; if (rdy_k != 3 || done_k != 4) begin miscompares++; $display("FAIL wr_done_timing: ready T+%0d done T+%0d want T+3 T+4", rdy_k, done_k); end
        vectors++; if (n_done != 1 || n_sv != 0 || n_en != 1) begin miscompares++; $display("FAIL wr_counts: done %0d sv %0d en %0d want 1 0 1", n_done, n_sv, n_en); end
    endtask

    task automatic test_back_to_back;
        int got, n;
        int ids[5], lens[5];
        logic [EW-1:0] d0[5], dl[5];
        step();
        strm_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_cmd(1'b0, AW'(10'h100 + i), LW'(i), IW'(i), '0);
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_full: ready %b busy %b want 0 1", cmd_ready, busy); end
        vectors++; if (strm_valid !== 1'b1 || strm_stream_id !== 5'd1) begin miscompares++; $display("FAIL b2b_first_out: valid %b id %0d want 1 1", strm_valid, strm_stream_id); end
        repeat (3) @(negedge clk);
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_still_full: ready %b want 0", cmd_ready); end
        step();
        strm_ready = 1'b1;
        got = 0; n = 0;
        while (got < 5 && n < 200) begin
            @(negedge clk);
            n++;
            if (strm_valid) begin
                ids[got] = int'(strm_stream_id); lens[got] = int'(strm_length);
                d0[got] = strm_data[0]; dl[got] = strm_data[strm_length];
                got++;
            end
        end
        vectors++; if (got != 5) begin miscompares++; $display("FAIL b2b_count: got %0d streams want 5", got); end
        for (int j = 0; j < got; j++) begin
            vectors++;
            if (ids[j] != j + 1 || lens[j] != j + 1 || d0[j] !== (16'h1111 ^ EW'(16'h00F1 + j)) || dl[j] !== 16'h0) begin
                miscompares++;
                $display("FAIL b2b_stream%0d: id %0d len %0d d0 %h dlen %h want %0d %0d %h 0000", j, ids[j], lens[j], d0[j], dl[j], j + 1, j + 1, 16'h1111 ^ EW'(16'h00F1 + j));
            end
        end
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_drained: busy %b ready %b want 0 1", busy, cmd_ready); end
    endtask

    task automatic test_bad_len;
        step();
        strm_ready = 1'b1;
        clr_counts();
        send_cmd(1'b0, 10'h030, 5'd0, 5'd4, '0);
        send_cmd(1'b0, 10'h031, 5'd21, 5'd5, '0);
        repeat (6) @(negedge clk);
        vectors++; if (n_err != 2) begin miscompares++; $display("FAIL bad_err_count: got %0d want 2", n_err); end
        vectors++; if (n_en != 0 || n_sv != 0 || busy !== 1'b0) begin miscompares++; $display("FAIL bad_not_queued: en %0d sv %0d busy %b want 0 0 0", n_en, n_sv, busy); end
        vectors++; if (cmd_ready !== 1'b1 || cmd_error !== 1'b0) begin miscompares++; $display("FAIL bad_after: ready %b err %b want 1 0", cmd_ready, cmd_error); end
        step();
        send_cmd(1'b1, 10'h032, 5'd25, 5'd6, '0);
        @(negedge clk);
        vectors++; if (cmd_error !== 1'b1) begin miscompares++; $display("FAIL bad_pulse_hi: got %b want 1", cmd_error); end
        @(negedge clk);
        vectors++; if (cmd_error !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL bad_pulse_lo: err %b busy %b want 0 0", cmd_error, busy); end
    endtask

    task automatic test_stray_ready;
        step();
        clr_counts();
        mem_mode = 2;
        repeat (4) step();
        mem_mode = 0;
        repeat (3) @(negedge clk);
        vectors++; if (n_done != 0 || n_sv != 0 || busy !== 1'b0) begin miscompares++; $display("FAIL stray_ready: done %0d sv %0d busy %b want 0 0 0", n_done, n_sv, busy); end
    endtask

    task automatic test_timeout;
        int tmo_k, en1_k, en2_k, sv_k;
        logic [AW-1:0] a1, a2, a_mid;
        logic [IW-1:0] sv_id;
        tmo_k = -1; en1_k = -1; en2_k = -1; sv_k = -1; a1 = '0; a2 = '0; a_mid = '0; sv_id = '0;
        step();
        strm_ready = 1'b1;
        mem_mode = 1;
        clr_counts();
        send_cmd(1'b0, 10'h040, 5'd4, 5'd9, '0);
        send_cmd(1'b0, 10'h050, 5'd2, 5'd10, '0);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (mem_read_enable) begin
                if (en1_k < 0) begin en1_k = k; a1 = mem_address; end
                else if (en2_k < 0) begin en2_k = k; a2 = mem_address; end
            end
            if (k == 10) a_mid = mem_address;
            if (mem_timeout && tmo_k < 0) tmo_k = k;
            if (strm_valid && sv_k < 0) begin sv_k = k; sv_id = strm_stream_id; end
            if (k == 17) mem_mode = 0;
        end
        vectors++; if (en1_k != 1 || a1 !== 10'h040) begin miscompares++; $display("FAIL tmo_first_issue: k %0d addr %h want 1 040", en1_k, a1); end
        vectors++; if (a_mid !== 10'h040) begin miscompares++; $display("FAIL tmo_addr_stable: got %h want 040", a_mid); end
        vectors++; if (tmo_k != 16 || n_tmo != 1) begin miscompares++; $display("FAIL tmo_pulse: k %0d count %0d want 16 1", tmo_k, n_tmo); end
        vectors++; if (en2_k != 18 || a2 !== 10'h050) begin miscompares++; $display("FAIL tmo_next_issue: k %0d addr %h want 18 050", en2_k, a2); end
        vectors++; if (sv_k != 20 || sv_id !== 5'd10 || n_sv != 1) begin miscompares++; $display("FAIL tmo_next_stream: k %0d id %0d n %0d want 20 10 1", sv_k, sv_id, n_sv); end
    endtask

    task automatic test_reset_mid;
        int n;
        step();
        strm_ready = 1'b0;
        mem_mode = 0;
        for (int i = 1; i <= 3; i++) send_cmd(1'b0, AW'(10'h060 + i), 5'd2, IW'(i), '0);
        n = 0;
        @(negedge clk);
        while (!strm_valid && n < 20) begin @(negedge clk); n++; end
        vectors++; if (strm_valid !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL rmid_pre: valid %b busy %b want 1 1", strm_valid, busy); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (strm_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            miscompares++; $display("FAIL rmid_async: valid %b busy %b ready %b want 0 0 0", strm_valid, busy, cmd_ready); end
        vectors++; if (mem_address !== '0 || strm_stream_id !== '0 || strm_data !== '0) begin
            miscompares++; $display("FAIL rmid_regs: addr %h id %h data %h want 0", mem_address, strm_stream_id, strm_data); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        strm_ready = 1'b1;
        clr_counts();
        repeat (10) @(negedge clk);
        vectors++; if (n_en != 0 || n_sv != 0 || n_done != 0) begin miscompares++; $display("FAIL rmid_after: en %0d sv %0d done %0d want 0 0 0", n_en, n_sv, n_done); end
        vectors++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_idle: busy %b ready %b want 0 1", busy, cmd_ready); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_bad_len();
        test_stray_ready();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
